// File: rtl/sbqm_sensor_driver.sv
// Photocell stimulus generator for the bank queue manager: turns arrive/depart request
// handshakes into single timed beam-break pulses on the back (a) and front (b) sensor lines.
module sbqm_sensor_driver #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 2,
  parameter int unsigned MAX_P     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arrive_req,
  input  logic       depart_req,
  input  logic       emptyFlag,
  input  logic       fullFlag,
  output logic       a,
  output logic       b,
  output logic       arrive_ack,
  output logic       depart_ack,
  output logic       rejected,
  output logic       busy,
  output logic [2:0] pCountShadow
);

  typedef enum logic [1:0] {StIdle, StPulseA, StPulseB, StGap} state_e;

  localparam logic [7:0] PulseLoad = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GapLoad   = 8'(GAP_LEN - 1);
  localparam logic [2:0] MaxCount  = 3'(MAX_P);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] count_q, count_d;
  logic       arrive_ack_q, arrive_ack_d;
  logic       depart_ack_q, depart_ack_d;
  logic       rejected_q, rejected_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      count_q      <= 3'd0;
      arrive_ack_q <= 1'b0;
      depart_ack_q <= 1'b0;
      rejected_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      arrive_ack_q <= arrive_ack_d;
      depart_ack_q <= depart_ack_d;
      rejected_q   <= rejected_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    count_d      = count_q;
    arrive_ack_d = 1'b0;
    depart_ack_d = 1'b0;
    rejected_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Departure has priority: it frees space, and a pending arrival simply waits.
        if (depart_req) begin
          depart_ack_d = 1'b1;
          if (emptyFlag || (count_q == 3'd0)) begin
            rejected_d = 1'b1;
          end else begin
            state_d = StPulseB;
            cnt_d   = PulseLoad;
          end
        end else if (arrive_req) begin
          arrive_ack_d = 1'b1;
          if (fullFlag || (count_q == MaxCount)) begin
            rejected_d = 1'b1;
          end else begin
            state_d = StPulseA;
            cnt_d   = PulseLoad;
          end
        end
      end
      StPulseA, StPulseB: begin
        if (cnt_q == 8'd0) begin
          // Line rises this edge; that is the consumer's count event.
          if (state_q == StPulseA) begin
            if (count_q != MaxCount) count_d = count_q + 3'd1;
          end else begin
            if (count_q != 3'd0) count_d = count_q - 3'd1;
          end
          if (GAP_LEN == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Lines decode straight from state so reset releases them without a clock edge.
  assign a            = (state_q != StPulseA);
  assign b            = (state_q != StPulseB);
  assign busy         = (state_q != StIdle);
  assign arrive_ack   = arrive_ack_q;
  assign depart_ack   = depart_ack_q;
  assign rejected     = rejected_q;
  assign pCountShadow = count_q;

endmodule

// File: tb/tb_sbqm_sensor_driver.sv
// Scoreboard bench for sbqm_sensor_driver: stimulus queues expected acks and pulses,
// independent monitors pop and compare them as the DUT produces them.
module tb_sbqm_sensor_driver;

  localparam int unsigned PULSE_LEN = 4;
  localparam int unsigned GAP_LEN   = 2;
  localparam int unsigned MAX_P     = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       arrive_req = 1'b0;
  logic       depart_req = 1'b0;
  logic       emptyFlag, fullFlag;
  logic       a, b, arrive_ack, depart_ack, rejected, busy;
  logic [2:0] pCountShadow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_cnt = 0;

  typedef struct packed {logic is_dep; logic rej;} ack_t;
  typedef struct packed {logic is_b; logic [2:0] cnt;} pulse_t;
  ack_t   ack_q[$];
  pulse_t pulse_q[$];

  // Queue-manager flags modelled from the occupancy the consumer would see.
  assign fullFlag  = (pCountShadow == 3'd7);
  assign emptyFlag = (pCountShadow == 3'd0);

  sbqm_sensor_driver #(
    .PULSE_LEN(PULSE_LEN),
    .GAP_LEN  (GAP_LEN),
    .MAX_P    (MAX_P)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arrive_req  (arrive_req),
    .depart_req  (depart_req),
    .emptyFlag   (emptyFlag),
    .fullFlag    (fullFlag),
    .a           (a),
    .b           (b),
    .arrive_ack  (arrive_ack),
    .depart_ack  (depart_ack),
    .rejected    (rejected),
    .busy        (busy),
    .pCountShadow(pCountShadow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Ack monitor.
  always @(negedge clk) begin
    ack_t e;
    if (!reset && (arrive_ack || depart_ack)) begin
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        e = ack_q.pop_front();
        chk("ack_kind_depart", int'(depart_ack), int'(e.is_dep));
        chk("ack_not_both", int'(arrive_ack & depart_ack), 0);
        chk("ack_rejected", int'(rejected), int'(e.rej));
      end
    end
  end

  task automatic check_pulse(input logic is_b, input int len);
    pulse_t p;
    if (pulse_q.size() == 0) begin
      chk("unexpected_pulse", 1, 0);
    end else begin
      p = pulse_q.pop_front();
      chk("pulse_line_is_b", int'(is_b), int'(p.is_b));
      chk("pulse_len", len, int'(PULSE_LEN));
      chk("shadow_at_rise", int'(pCountShadow), int'(p.cnt));
    end
  endtask

  // Pulse monitor: measures low runs on a and b, checks exclusivity each cycle.
  int run_a = 0;
  int run_b = 0;
  always @(negedge clk) begin
    if (reset) begin
      run_a <= 0;
      run_b <= 0;
    end else begin
      chk("lines_exclusive", int'(!a && !b), 0);
      if (!a) run_a <= run_a + 1;
      else if (run_a > 0) begin
        check_pulse(1'b0, run_a);
        run_a <= 0;
      end
      if (!b) run_b <= run_b + 1;
      else if (run_b > 0) begin
        check_pulse(1'b1, run_b);
        run_b <= 0;
      end
    end
  end

  task automatic wait_ack(input bit is_dep, output int ack_cyc);
    bit got = 0;
    ack_cyc = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (is_dep ? depart_ack : arrive_ack) begin
        got = 1;
        ack_cyc = cyc;
      end
    end
    chk(is_dep ? "depart_ack_seen" : "arrive_ack_seen", int'(got), 1);
    if (is_dep) depart_req = 1'b0;
    else arrive_req = 1'b0;
  endtask

  task automatic expect_req(input bit is_dep, input bit rej, input bit completes);
    ack_t e;
    pulse_t p;
    e.is_dep = is_dep;
    e.rej = rej;
    ack_q.push_back(e);
    if (!rej && completes) begin
      m_cnt = is_dep ? m_cnt - 1 : m_cnt + 1;
      p.is_b = is_dep;
      p.cnt = 3'(m_cnt);
      pulse_q.push_back(p);
    end
  endtask

  task automatic do_req(input bit is_dep, input bit rej, input bit completes,
                        output int ack_cyc);
    expect_req(is_dep, rej, completes);
    if (is_dep) depart_req = 1'b1;
    else arrive_req = 1'b1;
    wait_ack(is_dep, ack_cyc);
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    chk("idle_reached", int'(got), 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    int c, ta, td;
    repeat (3) @(negedge clk);
    chk("rst_a", int'(a), 1);
    chk("rst_b", int'(b), 1);
    chk("rst_arrive_ack", int'(arrive_ack), 0);
    chk("rst_depart_ack", int'(depart_ack), 0);
    chk("rst_rejected", int'(rejected), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_shadow", int'(pCountShadow), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset in the middle of PULSE_A.
    do_req(1'b0, 1'b0, 1'b0, c);
    @(posedge clk);
    #1 chk("t1_a_low_before_reset", int'(a), 0);
    reset = 1'b1;
    #1;
    chk("t1_a_async_high", int'(a), 1);
    chk("t1_shadow_kept", int'(pCountShadow), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_acks", int'(arrive_ack | depart_ack), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_cnt = 0;

    // Departure while empty is refused with no pulse.
    do_req(1'b1, 1'b1, 1'b1, c);
    chk("t4_busy_at_ack", int'(busy), 0);
    chk("t4_b_idle", int'(b), 1);
    @(negedge clk);
    chk("t4_busy_after", int'(busy), 0);
    chk("t4_b_after", int'(b), 1);

    // Single arrival with cycle-exact timing; a second arrival raised during GAP.
    expect_req(1'b0, 1'b0, 1'b1);
    arrive_req = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t2_a_k%0d", k), int'(a), (k <= 4 || k == 8) ? 0 : 1);
      chk($sformatf("t2_busy_k%0d", k), int'(busy), (k <= 6 || k == 8) ? 1 : 0);
      chk($sformatf("t2_ack_k%0d", k), int'(arrive_ack), (k == 1 || k == 8) ? 1 : 0);
      chk($sformatf("t2_shadow_k%0d", k), int'(pCountShadow), (k >= 5) ? 1 : 0);
      if (k == 1 || k == 8) arrive_req = 1'b0;
      if (k == 6) begin
        expect_req(1'b0, 1'b0, 1'b1);
        arrive_req = 1'b1;
      end
    end
    wait_idle();
    chk("t2_shadow_end", int'(pCountShadow), 2);
    pulse_reset();

    // Fill to capacity: seven pulses, eighth arrival refused.
    for (int i = 0; i < 8; i++) do_req(1'b0, (i == 7), 1'b1, c);
    wait_idle();
    chk("t3_shadow_full", int'(pCountShadow), 7);

    // Drain to three, then simultaneous arrive and depart.
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, 1'b1, c);
    wait_idle();
    chk("t5_shadow_start", int'(pCountShadow), 3);
    expect_req(1'b1, 1'b0, 1'b1);
    expect_req(1'b0, 1'b0, 1'b1);
    arrive_req = 1'b1;
    depart_req = 1'b1;
    wait_ack(1'b1, td);
    wait_ack(1'b0, ta);
    chk("t5_arrive_after_depart", ta - td, int'(PULSE_LEN + GAP_LEN + 1));
    wait_idle();
    chk("t5_shadow_end", int'(pCountShadow), 3);

    // Departure raised during PULSE_A waits for IDLE and is served once.
    do_req(1'b0, 1'b0, 1'b1, ta);
    @(posedge clk);
    #1 chk("t6_busy_when_raised", int'(busy), 1);
    do_req(1'b1, 1'b0, 1'b1, td);
    chk("t6_depart_latency", td - ta, int'(PULSE_LEN + GAP_LEN + 1));
    wait_idle();
    repeat (4) @(negedge clk);
    chk("t6_shadow_end", int'(pCountShadow), 3);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("pulse_queue_drained", pulse_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sbqm_sensor_driver.md
# sbqm_sensor_driver

Photocell stimulus generator for the bank queue manager: converts arrive/depart request handshakes into correctly timed beam-break pulses on the back (`a`) and front (`b`) sensor lines that the queue manager consumes. It refuses arrivals when the queue is full and departures when it is empty, and keeps a shadow person count. It sits between a customer-traffic model (or test sequencer) and the queue manager's `a`/`b` inputs. It replaces free-running toggling stimulus with a single-pulse-per-event protocol.

## Interface

- `PULSE_LEN`, 4: cycles a sensor line is held low (beam blocked) per event; valid range 1–255.
- `GAP_LEN`, 2: idle cycles after each pulse before the next request is accepted; valid range 0–255.
- `MAX_P`, 7: queue capacity; the shadow count saturates here.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `arrive_req`  in  1  customer-arrival request; held high until `arrive_ack`.
- `depart_req`  in  1  customer-departure request; held high until `depart_ack`.
- `emptyFlag`  in  1  queue-manager empty flag.
- `fullFlag`  in  1  queue-manager full flag.
- `a`  out  1  back sensor line; idle 1, low means blocked.
- `b`  out  1  front sensor line; idle 1, low means blocked.
- `arrive_ack`  out  1  one-cycle acknowledge of an arrival request.
- `depart_ack`  out  1  one-cycle acknowledge of a departure request.
- `rejected`  out  1  valid with either ack; 1 means the request was refused and no pulse is generated.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `pCountShadow`  out  3  expected queue occupancy.

## Operation

- FSM states: IDLE, PULSE_A, PULSE_B, GAP. Pulse length and gap use one 8-bit down-counter.
- **IDLE, accepting requests.**
  - If `depart_req` is high, the departure is served. Departure wins over a simultaneous `arrive_req`, because it frees space. The arrival stays pending.
  - Departure when `emptyFlag`=1 or `pCountShadow`=0: assert `depart_ack` and `rejected`, then stay in IDLE.
  - Otherwise: assert `depart_ack`, drive `b`=0, go to PULSE_B.
  - Arrival, otherwise: reject if `fullFlag`=1 or `pCountShadow`=MAX_P. If not rejected, drive `a`=0 and go to PULSE_A.
- **PULSE_A / PULSE_B.**
  - The line is held low for exactly PULSE_LEN cycles, then returns to 1; that 0→1 edge is the consumer's count event.
  - In the cycle the line returns high, `pCountShadow` increments (arrival) or decrements (departure), and the FSM goes to GAP.
  - If GAP_LEN=0 the FSM goes straight to IDLE.
- **GAP.** Holds both lines at 1 for GAP_LEN cycles, then returns to IDLE. GAP_LEN must cover the queue manager's flag-update latency.
- **Line exclusivity.** `a` and `b` are never low in the same cycle.
- **Shadow count.** Never wraps: it saturates at MAX_P and at 0, because requests are gated. The flags and the shadow count are ORed for refusal.
- **Request hold-off.** Requests arriving while `busy`=1 are not acknowledged; they wait, held high, until IDLE.
- **Reset values.** `a`=1, `b`=1, `arrive_ack`=0, `depart_ack`=0, `rejected`=0, `busy`=0, `pCountShadow`=0, state IDLE, counter 0.
- **Reset mid-pulse.** The line returns to 1 asynchronously. The partial pulse is not counted in the shadow count; the system resets the queue manager together with this block.

## Timing

- Request sampled high in IDLE at edge t.
  - Ack (and `rejected` if refused) is high for cycle t+1 only.
  - For an accepted request, the sensor line is low during cycles t+1..t+PULSE_LEN and high from t+PULSE_LEN+1.
- `busy` is high from t+1 through the last GAP cycle, t+PULSE_LEN+GAP_LEN.
- Earliest next acceptance is at edge t+PULSE_LEN+GAP_LEN+1.
- A refused request costs one cycle: the next request can be sampled at edge t+1.
- `pCountShadow` updates at edge t+PULSE_LEN, visible in the same cycle the line rises.
- Requester rule: drop `req` in the cycle after ack. A `req` still high in IDLE is treated as a new request.

## Test plan

Parameters for all scenarios: PULSE_LEN=4, GAP_LEN=2, MAX_P=7.

1. **Reset.** Assert `reset` mid-PULSE_A → `a` goes to 1 without waiting for a clock edge, `pCountShadow` stays at its pre-pulse value, all acks are 0.
2. **Single arrival.** `arrive_req` sampled high at edge 10 → `arrive_ack`=1 in cycle 11, `a`=0 in cycles 11–14, `a`=1 in cycle 15, `pCountShadow`=1 in cycle 15, `busy` falls after cycle 16, next acceptance at edge 17.
3. **Fill to capacity.** 8 back-to-back arrivals with `fullFlag` tied to `pCountShadow`==7 → 7 pulses on `a`, 8th ack has `rejected`=1 with no pulse, `pCountShadow`=7.
4. **Empty departure.** Departure at reset (`emptyFlag`=1) → `depart_ack`=1 and `rejected`=1 in the next cycle, `b` stays 1, `busy` stays 0.
5. **Simultaneous requests.** Occupancy 3, `arrive_req` and `depart_req` sampled high in the same cycle → departure served first (pulse on `b`, shadow 2), then arrival served at the first IDLE edge after the gap (shadow 3), with the lines never low together.
6. **Request during busy.** `depart_req` raised during PULSE_A → no ack until IDLE, then served exactly once.
